// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative comparator and the branch logic.
// Contents: compare-mode encodings, FSM state encoding, and helpers
// that classify a mode and decode the boolean outcome from eq/lt.
package cmp_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_LTU = 3'd3,
    CMP_GE  = 3'd4,
    CMP_GEU = 3'd5
  } cmp_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } cmp_state_t;

  // Signed modes are handled by flipping the operand sign bits at capture.
  function automatic logic is_signed_mode(input logic [2:0] m);
    return (m == CMP_LT) || (m == CMP_GE);
  endfunction

  // Encodings 6 and 7 are reserved.
  function automatic logic is_reserved_mode(input logic [2:0] m);
    return (m > CMP_GEU);
  endfunction

  function automatic logic decode_result(input logic [2:0] m,
                                         input logic       eq,
                                         input logic       lt);
    logic r;
    r = 1'b0;
    case (m)
      CMP_EQ:           r = eq;
      CMP_NE:           r = !eq;
      CMP_LT, CMP_LTU:  r = lt;
      CMP_GE, CMP_GEU:  r = !lt;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one operand slice.
// Ports:
//   a, b : slice operands (SLICE bits)
//   neq  : a != b
//   lt   : a < b, unsigned
module cmp_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             neq,
  output logic             lt
);

  always_comb begin
    neq = (a != b);
    lt  = (a < b);
  end

endmodule

// File: rtl/iter_compare_unit.sv
// Multi-cycle WIDTH-bit comparator: scans one SLICE-bit slice per cycle,
// most-significant slice first, with valid/ready on both sides.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   in_valid, in_ready   : input handshake
//   op_a, op_b, mode     : operands and compare mode (6,7 reserved)
//   out_valid, out_ready : output handshake
//   result, eq, lt       : selected outcome, A==B, A<B (signedness per mode)
//   mode_err             : captured mode is a reserved encoding
//   busy                 : unit is not idle
module iter_compare_unit
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SLICE      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             eq,
  output logic             lt,
  output logic             mode_err,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  cmp_state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sign_bit;
  logic [2:0]       mode_q;
  logic [IDXW-1:0]  idx;
  logic             eq_q, lt_q, result_q, mode_err_q;
  logic             diff_seen, first_lt;

  logic [SLICE-1:0] a_sl, b_sl;
  logic             s_neq, s_lt;
  logic             accept, scan_end, fin_eq, fin_lt;

  always_comb begin
    sign_bit           = '0;
    sign_bit[WIDTH-1]  = 1'b1;
  end

  assign a_sl = a_q[idx*SLICE +: SLICE];
  assign b_sl = b_q[idx*SLICE +: SLICE];

  cmp_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .neq (s_neq),
    .lt  (s_lt)
  );

  assign in_ready  = (state == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign mode_err  = mode_err_q;

  // Without early exit the first (most-significant) difference is remembered
  // in diff_seen/first_lt and only reported once slice 0 has been scanned.
  always_comb begin
    state_next = state;
    scan_end   = 1'b0;
    fin_eq     = 1'b0;
    fin_lt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = is_reserved_mode(mode) ? DONE : SCAN;
      end
      SCAN: begin
        if (EARLY_EXIT && s_neq) begin
          scan_end = 1'b1;
          fin_eq   = 1'b0;
          fin_lt   = s_lt;
        end else if (idx == '0) begin
          scan_end = 1'b1;
          fin_eq   = !(diff_seen || s_neq);
          fin_lt   = diff_seen ? first_lt : (s_neq && s_lt);
        end
        if (scan_end) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      idx        <= '0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      result_q   <= 1'b0;
      mode_err_q <= 1'b0;
      diff_seen  <= 1'b0;
      first_lt   <= 1'b0;
    end else if (accept) begin
      a_q        <= op_a ^ (is_signed_mode(mode) ? sign_bit : '0);
      b_q        <= op_b ^ (is_signed_mode(mode) ? sign_bit : '0);
      mode_q     <= mode;
      idx        <= IDX_TOP;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      result_q   <= 1'b0;
      mode_err_q <= is_reserved_mode(mode);
      diff_seen  <= 1'b0;
      first_lt   <= 1'b0;
    end else if (state == SCAN) begin
      if (scan_end) begin
        eq_q     <= fin_eq;
        lt_q     <= fin_lt;
        result_q <= decode_result(mode_q, fin_eq, fin_lt);
      end else begin
        idx <= idx - 1'b1;
        if (s_neq && !diff_seen) begin
          diff_seen <= 1'b1;
          first_lt  <= s_lt;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_compare_unit.sv
// Self-checking bench for iter_compare_unit: two instances (early exit on
// and off) share stimulus; results and latency are checked against a
// fixed vector table, a behavioural model and hand-written corner cases.
module tb_iter_compare_unit;

  localparam int NS = 4;
  localparam int SL = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [2:0]  mode = '0;

  logic in_ready1, out_valid1, result1, eq1, lt1, err1, busy1;
  logic in_ready0, out_valid0, result0, eq0, lt0, err0, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  iter_compare_unit #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid1),
    .out_ready(out_ready), .result(result1), .eq(eq1), .lt(lt1),
    .mode_err(err1), .busy(busy1)
  );

  iter_compare_unit #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid0),
    .out_ready(out_ready), .result(result0), .eq(eq0), .lt(lt0),
    .mode_err(err0), .busy(busy0)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic        res;
    logic        eq;
    logic        lt;
    logic        err;
    int          lat1;
    int          lat0;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic; latency from position of first differing slice.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] m);
    vec_t e;
    int   k;
    e.a = a; e.b = b; e.m = m;
    if (m > 3'd5) begin
      e.res = 1'b0; e.eq = 1'b0; e.lt = 1'b0; e.err = 1'b1;
      e.lat1 = 1; e.lat0 = 1;
      return e;
    end
    e.err = 1'b0;
    e.eq  = (a == b);
    if (m == 3'd2 || m == 3'd4) e.lt = ($signed(a) < $signed(b));
    else                        e.lt = (a < b);
    case (m)
      3'd0:        e.res = e.eq;
      3'd1:        e.res = !e.eq;
      3'd2, 3'd3:  e.res = e.lt;
      default:     e.res = !e.lt;
    endcase
    k = NS;
    for (int s = NS - 1; s >= 0; s--) begin
      if (((a >> (s * SL)) & 32'hFF) != ((b >> (s * SL)) & 32'hFF)) begin
        k = NS - s;
        break;
      end
    end
    e.lat1 = k + 1;
    e.lat0 = NS + 1;
    return e;
  endfunction

  task automatic run_cmp(input vec_t v, input string tag);
    int l1, l0;
    l1 = 0; l0 = 0;
    op_a = v.a; op_b = v.b; mode = v.m; in_valid = 1'b1;
    chk_b({tag, ".in_ready"}, in_ready1, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (out_valid1 && l1 == 0) l1 = cyc;
      if (out_valid0 && l0 == 0) l0 = cyc;
      if (l1 != 0 && l0 != 0) break;
      tick();
    end
    chk_i({tag, ".lat1"}, l1, v.lat1);
    chk_i({tag, ".lat0"}, l0, v.lat0);
    chk_b({tag, ".res1"}, result1, v.res);
    chk_b({tag, ".eq1"},  eq1,     v.eq);
    chk_b({tag, ".lt1"},  lt1,     v.lt);
    chk_b({tag, ".err1"}, err1,    v.err);
    chk_b({tag, ".res0"}, result0, v.res);
    chk_b({tag, ".eq0"},  eq0,     v.eq);
    chk_b({tag, ".lt0"},  lt0,     v.lt);
    chk_b({tag, ".err0"}, err0,    v.err);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_b({tag, ".ovalid_drop"}, out_valid1 | out_valid0, 1'b0);
    chk_b({tag, ".ready_back"},  in_ready1 & in_ready0,   1'b1);
  endtask

  initial begin
    vec_t v;
    bit   seen;

    vecs[0] = '{32'h12345678, 32'h12345678, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 5};
    vecs[1] = '{32'h80000000, 32'h00000001, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2, 5};
    vecs[2] = '{32'h80000000, 32'h00000001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2, 5};
    vecs[3] = '{32'h000000FF, 32'h000000FE, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5, 5};
    vecs[4] = '{32'hFF000000, 32'h00000000, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5};
    vecs[5] = '{32'hDEADBEEF, 32'h01234567, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[6] = '{32'h00000005, 32'h00000005, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5, 5};
    vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5};
    vecs[8] = '{32'h00000000, 32'h00000000, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[9] = '{32'h00010000, 32'h00020000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3, 5};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk_b("rst.out_valid", out_valid1, 1'b0);
    chk_b("rst.busy",      busy1,      1'b0);
    chk_b("rst.result",    result1,    1'b0);
    chk_b("rst.eq",        eq1,        1'b0);
    chk_b("rst.lt",        lt1,        1'b0);
    chk_b("rst.mode_err",  err1,       1'b0);
    chk_b("rst.in_ready",  in_ready1 | in_ready0, 1'b0);
    reset = 1'b0;
    tick();
    chk_b("rst.in_ready_after", in_ready1 & in_ready0, 1'b1);

    // Table vectors
    for (int i = 0; i < 10; i++) run_cmp(vecs[i], $sformatf("vec%0d", i));

    // Result held while out_ready low; input pulsed during DONE is ignored
    op_a = 32'h00000003; op_b = 32'h00000007; mode = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && !(out_valid1 && out_valid0); cyc++) tick();
    chk_b("hold.reached_done", out_valid1 & out_valid0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      op_a = 32'h9; op_b = 32'h9; mode = 3'd0; in_valid = 1'b1;
      chk_b($sformatf("hold%0d.res", i),      result1,   1'b1);
      chk_b($sformatf("hold%0d.lt", i),       lt1,       1'b1);
      chk_b($sformatf("hold%0d.eq", i),       eq1,       1'b0);
      chk_b($sformatf("hold%0d.in_ready", i), in_ready1 | in_ready0, 1'b0);
      chk_b($sformatf("hold%0d.ovalid", i),   out_valid1, 1'b1);
      tick();
    end
    chk_b("hold.res_final", result1 & result0, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_b("hold.ovalid_drop", out_valid1 | out_valid0, 1'b0);
    chk_b("hold.in_ready",    in_ready1 & in_ready0,   1'b1);
    chk_b("hold.not_busy",    busy1 | busy0,           1'b0);

    // Reset in second SCAN cycle of an equal-operand compare
    op_a = 32'hCAFEBABE; op_b = 32'hCAFEBABE; mode = 3'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk_b("abort.busy_before", busy1 & busy0, 1'b1);
    reset = 1'b1;
    chk_b("abort.in_ready_rst", in_ready1 | in_ready0, 1'b0);
    tick();
    chk_b("abort.busy",   busy1 | busy0,           1'b0);
    chk_b("abort.ovalid", out_valid1 | out_valid0, 1'b0);
    reset = 1'b0;
    tick();
    chk_b("abort.in_ready", in_ready1 & in_ready0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid1 || out_valid0 || busy1 || busy0) seen = 1'b1;
      tick();
    end
    chk_b("abort.no_result", seen, 1'b0);

    // Randomised compares against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = a;
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 3) == 0) b[s*SL +: SL] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b[31] = ~b[31];
      v = model(a, b, 3'($urandom_range(0, 7)));
      run_cmp(v, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
